// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, clocks out one command byte
// on device-generated clocks and checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clock50,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_MAX = INH_W'(INHIBIT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t state, state_nxt;

  logic [1:0]            clk_sync, data_sync;
  logic [FILTER_LEN-1:0] clk_hist;
  logic                  clk_filt, clk_filt_d;
  logic                  fall;

  logic [INH_W-1:0] inh_cnt, inh_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_nxt, tmo_inc;
  logic [3:0]       bit_cnt, bit_nxt;
  logic [7:0]       tx_byte, byte_nxt;
  logic             parity, parity_nxt;
  logic             data_oe, data_oe_nxt;
  logic             tmo_hit;

  // The filtered clock only moves once the whole sample window agrees.
  always_ff @(posedge clock50) begin
    if (reset) begin
      clk_sync   <= 2'b11;
      data_sync  <= 2'b11;
      clk_hist   <= '1;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk_in};
      data_sync  <= {data_sync[0], ps2_data_in};
      clk_hist   <= {clk_hist[FILTER_LEN-2:0], clk_sync[1]};
      if (&clk_hist)
        clk_filt <= 1'b1;
      else if (~|clk_hist)
        clk_filt <= 1'b0;
      clk_filt_d <= clk_filt;
    end
  end

  assign fall = clk_filt_d & ~clk_filt;

  always_ff @(posedge clock50) begin
    if (reset) begin
      state   <= S_IDLE;
      inh_cnt <= '0;
      tmo_cnt <= '0;
      bit_cnt <= '0;
      tx_byte <= '0;
      parity  <= 1'b0;
      data_oe <= 1'b0;
    end else begin
      state   <= state_nxt;
      inh_cnt <= inh_nxt;
      tmo_cnt <= tmo_nxt;
      bit_cnt <= bit_nxt;
      tx_byte <= byte_nxt;
      parity  <= parity_nxt;
      data_oe <= data_oe_nxt;
    end
  end

  assign tmo_inc = (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + TMO_W'(1);
  assign tmo_hit = (tmo_inc == TMO_MAX);

  always_comb begin
    state_nxt   = state;
    inh_nxt     = inh_cnt;
    tmo_nxt     = tmo_cnt;
    bit_nxt     = bit_cnt;
    byte_nxt    = tx_byte;
    parity_nxt  = parity;
    data_oe_nxt = data_oe;
    unique case (state)
      S_IDLE: begin
        data_oe_nxt = 1'b0;
        if (tx_valid) begin
          state_nxt  = S_INHIBIT;
          inh_nxt    = '0;
          byte_nxt   = tx_data;
          parity_nxt = ~^tx_data;
        end
      end
      // Start bit goes low during the final inhibit cycle, before the clock is freed.
      S_INHIBIT: begin
        if (inh_cnt != INH_MAX)
          inh_nxt = inh_cnt + INH_W'(1);
        if (int'(inh_cnt) >= INHIBIT_CYCLES - 2)
          data_oe_nxt = 1'b1;
        if (int'(inh_cnt) >= INHIBIT_CYCLES - 1) begin
          state_nxt = S_SEND;
          tmo_nxt   = '0;
          bit_nxt   = '0;
        end
      end
      S_SEND: begin
        if (tmo_hit) begin
          state_nxt   = S_ERROR;
          data_oe_nxt = 1'b0;
        end else begin
          tmo_nxt = tmo_inc;
          if (fall) begin
            if (bit_cnt != 4'hF)
              bit_nxt = bit_cnt + 4'd1;
            if (bit_cnt < 4'd8)
              data_oe_nxt = ~tx_byte[bit_cnt[2:0]];
            else if (bit_cnt == 4'd8)
              data_oe_nxt = ~parity;
            else begin
              data_oe_nxt = 1'b0;
              state_nxt   = S_ACK;
            end
          end
        end
      end
      S_ACK: begin
        if (tmo_hit) begin
          state_nxt   = S_ERROR;
          data_oe_nxt = 1'b0;
        end else begin
          tmo_nxt = tmo_inc;
          if (fall)
            state_nxt = data_sync[1] ? S_ERROR : S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (tmo_hit) begin
          state_nxt   = S_ERROR;
          data_oe_nxt = 1'b0;
        end else begin
          tmo_nxt = tmo_inc;
          if (clk_filt && data_sync[1])
            state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      S_ERROR: begin
        data_oe_nxt = 1'b0;
        state_nxt   = S_IDLE;
      end
      default: begin
        state_nxt   = S_IDLE;
        data_oe_nxt = 1'b0;
      end
    endcase
  end

  assign ps2_clk_oe  = (state == S_INHIBIT);
  assign ps2_data_oe = data_oe;
  assign tx_ready    = (state == S_IDLE);
  assign rx_inhibit  = (state != S_IDLE);
  assign tx_done     = (state == S_DONE);
  assign tx_error    = (state == S_ERROR);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host
// and the sampled frames are compared against parity/framing computed from the byte.
module tb_ps2_host_tx;

  localparam int INH  = 200;
  localparam int TMO  = 3000;
  localparam int FLT  = 8;
  localparam int HALF = 40;

  logic       clock50 = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_done, tx_error, rx_inhibit;

  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  // Open-drain bus: either side can pull a line low.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (FLT)
  ) dut (
    .clock50    (clock50),
    .reset      (reset),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .rx_inhibit (rx_inhibit)
  );

  always #10 clock50 = ~clock50;

  always @(negedge clock50) begin
    if (tx_done)  done_cnt <= done_cnt + 1;
    if (tx_error) err_cnt  <= err_cnt + 1;
  end

  // Frame as seen by the device, in wire order: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] expected_frame(input logic [7:0] b);
    int ones;
    logic [10:0] f;
    ones = 0;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      ones += int'(b[i]);
      f[i+1] = b[i];
    end
    f[0]  = 1'b0;
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic start_tx(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clock50);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  // Device side: measures the inhibit, then generates n_clocks clock pulses,
  // sampling the data line late in each high phase; optionally ACKs and glitches.
  task automatic run_device(input int n_clocks, input bit ack, input bit glitch,
                            output logic [10:0] frame, output int inh_len,
                            output bit start_seen);
    int guard;
    frame      = '1;
    inh_len    = 0;
    start_seen = 1'b0;
    guard      = 0;
    while (ps2_clk_oe !== 1'b1 && guard < 100) begin
      @(negedge clock50);
      guard++;
    end
    while (ps2_clk_oe === 1'b1 && inh_len < INH + 100) begin
      inh_len++;
      @(negedge clock50);
    end
    start_seen = (ps2_data_oe === 1'b1);
    repeat (20) @(negedge clock50);
    for (int k = 0; k < n_clocks; k++) begin
      automatic int gw = (k == 1) ? 7 : int'($urandom_range(1, 7));
      for (int c = 0; c < HALF; c++) begin
        if (glitch && k >= 1 && k <= 8 && c == 16) dev_clk = 1'b0;
        if (glitch && k >= 1 && k <= 8 && c == 16 + gw) dev_clk = 1'b1;
        if (c == HALF - 4) begin
          if (k < 11) frame[k] = ps2_data_in;
          if (k == 10 && ack) dev_data = 1'b0;
        end
        @(negedge clock50);
      end
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clock50);
      dev_clk = 1'b1;
    end
    repeat (5) @(negedge clock50);
    dev_data = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock50);
    reset = 1'b0;
    @(negedge clock50);
    tests_run++;
    if (tx_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_tx_ready: got %b want 1", tx_ready); end
    tests_run++;
    if (ps2_clk_oe !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); end
    tests_run++;
    if (ps2_data_oe !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_data_oe: got %b want 0", ps2_data_oe); end
    tests_run++;
    if (rx_inhibit !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rx_inhibit: got %b want 0", rx_inhibit); end
    tests_run++;
    if ({tx_done, tx_error} !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_pulses: got %b want 00", {tx_done, tx_error}); end
  endtask

  task automatic test_frames();
    logic [7:0]  bytes [8];
    logic [10:0] frame, exp_f;
    int inh, d0, e0, g;
    bit start_ok;
    bytes[0] = 8'hED;
    bytes[1] = 8'h01;
    for (int i = 2; i < 8; i++) bytes[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      exp_f = expected_frame(bytes[i]);
      start_tx(bytes[i]);
      tests_run++;
      if ({tx_ready, ps2_clk_oe, rx_inhibit} !== 3'b011) begin
        tests_failed++;
        $display("[TB] FAIL accept_outputs %h: ready/clk_oe/inhibit got %b want 011", bytes[i], {tx_ready, ps2_clk_oe, rx_inhibit});
      end
      run_device(11, 1'b1, 1'b0, frame, inh, start_ok);
      tests_run++;
      if (inh != INH) begin tests_failed++; $display("[TB] FAIL inhibit_len %h: got %0d want %0d", bytes[i], inh, INH); end
      tests_run++;
      if (start_ok !== 1'b1) begin tests_failed++; $display("[TB] FAIL start_bit %h: data_oe at release got %b want 1", bytes[i], start_ok); end
      tests_run++;
      if (frame !== exp_f) begin tests_failed++; $display("[TB] FAIL frame %h: got %b want %b", bytes[i], frame, exp_f); end
      g = 0;
      while (tx_ready !== 1'b1 && g < 200) begin @(negedge clock50); g++; end
      repeat (2) @(negedge clock50);
      tests_run++;
      if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
        tests_failed++;
        $display("[TB] FAIL pulses %h: done/error got %0d/%0d want 1/0", bytes[i], done_cnt - d0, err_cnt - e0);
      end
      tests_run++;
      if ({tx_ready, rx_inhibit} !== 2'b10) begin
        tests_failed++;
        $display("[TB] FAIL back_idle %h: ready/inhibit got %b want 10", bytes[i], {tx_ready, rx_inhibit});
      end
    end
  endtask

  task automatic test_nack();
    logic [7:0]  b;
    logic [10:0] frame, exp_f;
    int inh, d0, e0, g;
    bit start_ok;
    b = 8'($urandom);
    exp_f = expected_frame(b);
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(b);
    run_device(11, 1'b0, 1'b0, frame, inh, start_ok);
    g = 0;
    while (tx_ready !== 1'b1 && g < 200) begin @(negedge clock50); g++; end
    repeat (2) @(negedge clock50);
    tests_run++;
    if (frame !== exp_f) begin tests_failed++; $display("[TB] FAIL nack_frame: got %b want %b", frame, exp_f); end
    tests_run++;
    if (done_cnt - d0 != 0 || err_cnt - e0 != 1) begin
      tests_failed++;
      $display("[TB] FAIL nack_pulses: done/error got %0d/%0d want 0/1", done_cnt - d0, err_cnt - e0);
    end
    tests_run++;
    if ({tx_ready, ps2_clk_oe, ps2_data_oe} !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL nack_idle: ready/clk_oe/data_oe got %b want 100", {tx_ready, ps2_clk_oe, ps2_data_oe});
    end
  endtask

  task automatic test_timeout();
    int g, k, d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'($urandom));
    g = 0;
    while (ps2_clk_oe === 1'b1 && g < INH + 100) begin @(negedge clock50); g++; end
    tests_run++;
    if ({ps2_clk_oe, rx_inhibit} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL timeout_release: clk_oe/inhibit got %b want 01", {ps2_clk_oe, rx_inhibit});
    end
    k = 0;
    while (tx_error !== 1'b1 && k < TMO + 50) begin @(negedge clock50); k++; end
    tests_run++;
    if (k != TMO) begin tests_failed++; $display("[TB] FAIL timeout_cycles: got %0d want %0d", k, TMO); end
    repeat (3) @(negedge clock50);
    tests_run++;
    if (done_cnt - d0 != 0 || err_cnt - e0 != 1 || tx_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL timeout_result: done/error/ready got %0d/%0d/%b want 0/1/1", done_cnt - d0, err_cnt - e0, tx_ready);
    end
  endtask

  task automatic test_glitch();
    logic [7:0]  b;
    logic [10:0] frame, exp_f;
    int inh, d0, e0, g;
    bit start_ok;
    b = 8'($urandom);
    exp_f = expected_frame(b);
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(b);
    run_device(11, 1'b1, 1'b1, frame, inh, start_ok);
    g = 0;
    while (tx_ready !== 1'b1 && g < 200) begin @(negedge clock50); g++; end
    repeat (2) @(negedge clock50);
    tests_run++;
    if (frame !== exp_f) begin tests_failed++; $display("[TB] FAIL glitch_frame: got %b want %b", frame, exp_f); end
    tests_run++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
      tests_failed++;
      $display("[TB] FAIL glitch_pulses: done/error got %0d/%0d want 1/0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_reset_mid_send();
    logic [10:0] frame;
    int inh, d0, e0;
    bit start_ok;
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'h00);
    run_device(4, 1'b1, 1'b0, frame, inh, start_ok);
    tests_run++;
    if ({ps2_data_oe, ps2_clk_oe, rx_inhibit} !== 3'b101) begin
      tests_failed++;
      $display("[TB] FAIL mid_send_state: data_oe/clk_oe/inhibit got %b want 101", {ps2_data_oe, ps2_clk_oe, rx_inhibit});
    end
    reset = 1'b1;
    @(negedge clock50);
    tests_run++;
    if ({ps2_clk_oe, ps2_data_oe, tx_ready, rx_inhibit} !== 4'b0010) begin
      tests_failed++;
      $display("[TB] FAIL mid_send_reset: clk_oe/data_oe/ready/inhibit got %b want 0010", {ps2_clk_oe, ps2_data_oe, tx_ready, rx_inhibit});
    end
    reset = 1'b0;
    repeat (50) @(negedge clock50);
    tests_run++;
    if (done_cnt - d0 != 0 || err_cnt - e0 != 0 || tx_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mid_send_after: done/error/ready got %0d/%0d/%b want 0/0/1", done_cnt - d0, err_cnt - e0, tx_ready);
    end
  endtask

  // tx_valid stays high across the whole first transfer while tx_data wanders;
  // only the value present when IDLE returns may be sent next.
  task automatic test_back_to_back();
    logic [7:0]  a, b, c;
    logic [10:0] f1, f2;
    int inh, d0, e0, g;
    bit start_ok;
    a = 8'($urandom);
    b = 8'($urandom);
    c = ~b;
    d0 = done_cnt;
    e0 = err_cnt;
    tx_data  = a;
    tx_valid = 1'b1;
    @(negedge clock50);
    tx_data = c;
    run_device(11, 1'b1, 1'b0, f1, inh, start_ok);
    tx_data = b;
    g = 0;
    while (tx_done !== 1'b1 && g < 200) begin @(negedge clock50); g++; end
    repeat (2) @(negedge clock50);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    tests_run++;
    if ({tx_ready, ps2_clk_oe} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second_accept: ready/clk_oe got %b want 01", {tx_ready, ps2_clk_oe});
    end
    run_device(11, 1'b1, 1'b0, f2, inh, start_ok);
    g = 0;
    while (tx_ready !== 1'b1 && g < 200) begin @(negedge clock50); g++; end
    repeat (30) @(negedge clock50);
    tests_run++;
    if (f1 !== expected_frame(a)) begin tests_failed++; $display("[TB] FAIL b2b_frame1: got %b want %b", f1, expected_frame(a)); end
    tests_run++;
    if (f2 !== expected_frame(b)) begin tests_failed++; $display("[TB] FAIL b2b_frame2: got %b want %b", f2, expected_frame(b)); end
    tests_run++;
    if (done_cnt - d0 != 2 || err_cnt - e0 != 0 || ps2_clk_oe !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_result: done/error/clk_oe got %0d/%0d/%b want 2/0/0", done_cnt - d0, err_cnt - e0, ps2_clk_oe);
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_nack();
    test_timeout();
    test_glitch();
    test_reset_mid_send();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
